grf_wb_arbiter: RTL and testbench

Write-port arbiter and scheduler for the 32×32 general register file (GRF). It shares the GRF's single write port between the in-order pipeline W stage and a long-latency unit (e.g. a multi-cycle divider returning a GPR result). The long-latency results are buffered in a small FIFO. A per-register pending scoreboard feeds the hazard unit, and a starvation counter forces a pipeline bubble so that buffered results always drain. The block sits between W stage, long-latency unit and GRF, and drives the GRF `WrEn/A3/WD/PC4` inputs directly.

---
 rtl/grf_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_grf_wb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the GRF write port between the W stage and a
// long-latency unit. Long-latency results wait in a small FIFO. A pending
// scoreboard tracks registers with outstanding writes. A starvation counter
// requests a W-stage bubble so that buffered results always drain.
module grf_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_a3,
    input  logic [31:0] pipe_wd,
    input  logic [31:0] pipe_pc4,
    input  logic        issue_valid,
    input  logic [4:0]  issue_a3,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_a3,
    input  logic [31:0] lu_wd,
    input  logic [31:0] lu_pc4,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc4,
    output logic [31:0] pending,
    output logic        stall_req
);

    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [3:0]    WMAX = 4'(MAX_WAIT);

    // Result storage; holds data only, so it carries no reset.
    logic [4:0]    mem_a3  [DEPTH];
    logic [31:0]   mem_wd  [DEPTH];
    logic [31:0]   mem_pc4 [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [3:0]    wait_cnt;
    logic [3:0]    wait_next;
    logic [31:0]   pending_next;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    // Saturating increment of the starvation counter.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == WMAX) ? v : v + 4'd1;
    endfunction

    assign fifo_empty = (count == '0);
    // Gated by reset so that the handshake is closed while reset is held.
    assign lu_ready   = reset & (count < FULL);
    // Results for $0 complete the handshake but never occupy a slot.
    assign push       = lu_valid & lu_ready & (lu_a3 != 5'd0);
    // The FIFO head only gets the port in cycles the W stage leaves free.
    assign pop        = reset & ~pipe_we & ~fifo_empty;

    // Write-port mux: W stage first, then the FIFO head, otherwise idle.
    always_comb begin
        grf_we  = 1'b0;
        grf_a3  = 5'd0;
        grf_wd  = 32'd0;
        grf_pc4 = 32'd0;
        if (reset) begin
            if (pipe_we) begin
                grf_we  = 1'b1;
                grf_a3  = pipe_a3;
                grf_wd  = pipe_wd;
                grf_pc4 = pipe_pc4;
            end else if (!fifo_empty) begin
                grf_we  = 1'b1;
                grf_a3  = mem_a3[rd_ptr];
                grf_wd  = mem_wd[rd_ptr];
                grf_pc4 = mem_pc4[rd_ptr];
            end
        end
    end

    // Capture an accepted long-latency result at the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a3[wr_ptr]  <= lu_a3;
            mem_wd[wr_ptr]  <= lu_wd;
            mem_pc4[wr_ptr] <= lu_pc4;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Scoreboard update: a drain clears, a new issue sets, and set wins.
    always_comb begin
        pending_next = pending;
        if (pop) pending_next[mem_a3[rd_ptr]] = 1'b0;
        if (issue_valid && (issue_a3 != 5'd0)) pending_next[issue_a3] = 1'b1;
        pending_next[0] = 1'b0;
    end

    // Register the scoreboard seen by the hazard unit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending <= 32'd0;
        else        pending <= pending_next;
    end

    // Count consecutive cycles the FIFO head lost arbitration.
    always_comb begin
        if (pop || fifo_empty) wait_next = 4'd0;
        else if (pipe_we)      wait_next = sat_inc(wait_cnt);
        else                   wait_next = wait_cnt;
    end

    // Starvation counter and the registered bubble request derived from it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= 4'd0;
            stall_req <= 1'b0;
        end else begin
            wait_cnt  <= wait_next;
            stall_req <= (wait_next == WMAX);
        end
    end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Testbench for grf_wb_arbiter: directed scenarios plus randomized traffic,
// with expected GRF writes queued by the stimulus and consumed by a monitor.
module tb_grf_wb_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc4;
    logic        issue_valid;
    logic [4:0]  issue_a3;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_a3;
    logic [31:0] lu_wd;
    logic [31:0] lu_pc4;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc4;
    logic [31:0] pending;
    logic        stall_req;

    grf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc4(pipe_pc4),
        .issue_valid(issue_valid), .issue_a3(issue_a3),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_a3(lu_a3), .lu_wd(lu_wd), .lu_pc4(lu_pc4),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc4(grf_pc4),
        .pending(pending), .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc4;
    } ent_t;

    // Reference model: buffered results, expected writes, scoreboard, starvation.
    ent_t        mq[$];
    ent_t        expq[$];
    logic [31:0] m_pend;
    int          m_lost;
    bit          m_stall;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        expq.delete();
        m_pend  = 32'd0;
        m_lost  = 0;
        m_stall = 1'b0;
    endtask

    // One clock cycle: drive inputs, check registered state, predict the
    // write of this cycle, then advance the model across the clock edge.
    task automatic step(input bit pw, input logic [4:0] pa3, input logic [31:0] pwd,
                        input logic [31:0] ppc, input bit iv, input logic [4:0] ia3,
                        input bit lv, input logic [4:0] la3, input logic [31:0] lwd,
                        input logic [31:0] lpc);
        bit   mr;
        bit   do_pop;
        bit   do_push;
        bit   was_empty;
        ent_t tmp;
        pipe_we = pw; pipe_a3 = pa3; pipe_wd = pwd; pipe_pc4 = ppc;
        issue_valid = iv; issue_a3 = ia3;
        lu_valid = lv; lu_a3 = la3; lu_wd = lwd; lu_pc4 = lpc;
        #1;
        mr = reset && (mq.size() < DEPTH);
        chk("lu_ready", 32'(lu_ready), 32'(mr));
        chk("pending", pending, m_pend);
        chk("stall_req", 32'(stall_req), 32'(m_stall));
        do_pop = 1'b0;
        do_push = 1'b0;
        was_empty = (mq.size() == 0);
        if (reset) begin
            if (pw) expq.push_back('{a3: pa3, wd: pwd, pc4: ppc});
            else if (!was_empty) begin
                expq.push_back(mq[0]);
                do_pop = 1'b1;
            end
            do_push = lv && mr && (la3 != 5'd0);
        end
        @(posedge clk);
        if (reset) begin
            if (do_pop) begin
                tmp = mq.pop_front();
                m_pend[tmp.a3] = 1'b0;
            end
            if (do_push) mq.push_back('{a3: la3, wd: lwd, pc4: lpc});
            if (iv && ia3 != 5'd0) m_pend[ia3] = 1'b1;
            m_pend[0] = 1'b0;
            if (do_pop || was_empty) m_lost = 0;
            else if (pw)             m_lost = (m_lost < MAX_WAIT) ? m_lost + 1 : MAX_WAIT;
            m_stall = (m_lost == MAX_WAIT);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every GRF write must match the oldest expected write.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (grf_we === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grf_unexpected: got write a3=%0d wd=0x%08h expected none at %0t",
                             grf_a3, grf_wd, $time);
                end else begin
                    e = expq.pop_front();
                    chk("grf_a3", 32'(grf_a3), 32'(e.a3));
                    chk("grf_wd", grf_wd, e.wd);
                    chk("grf_pc4", grf_pc4, e.pc4);
                end
            end else begin
                chk("grf_we_known", 32'(grf_we), 32'd0);
                chk("grf_idle_a3", 32'(grf_a3), 32'd0);
                chk("grf_idle_wd", grf_wd, 32'd0);
            end
        end
    end

    initial begin
        bit pw;
        reset = 1'b1;
        pipe_we = 0; pipe_a3 = 0; pipe_wd = 0; pipe_pc4 = 0;
        issue_valid = 0; issue_a3 = 0;
        lu_valid = 0; lu_a3 = 0; lu_wd = 0; lu_pc4 = 0;
        model_clear();
        #2 reset = 1'b0;
        pipe_we = 1'b1; pipe_a3 = 5'd5; pipe_wd = 32'h55;
        #1;
        chk("rst_lu_ready", 32'(lu_ready), 32'd0);
        chk("rst_grf_we", 32'(grf_we), 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        step(1, 5, 32'h77, 32'h4, 1, 3, 1, 4, 32'h88, 32'h8);
        reset = 1'b1;

        // Idle write-through
        step(1, 5, 32'h1234, 32'h100, 0, 0, 0, 0, 0, 0);

        // Scoreboard and drain
        step(0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        chk("pend7_set", 32'(pending[7]), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1, 7, 32'hCAFE, 32'h3004);
        idle(2);
        chk("pend7_clr", 32'(pending[7]), 32'd0);

        // Full and back-pressure
        step(1, 1, 32'h11, 32'h1000, 1, 10, 1, 10, 32'hA0A0, 32'h2000);
        step(1, 2, 32'h22, 32'h1004, 1, 11, 1, 11, 32'hB0B0, 32'h2004);
        chk("full_ready", 32'(lu_ready), 32'd0);
        step(1, 3, 32'h33, 32'h1008, 0, 0, 1, 12, 32'hC0C0, 32'h2008);
        step(0, 0, 0, 0, 0, 0, 1, 12, 32'hC0C0, 32'h2008);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Starvation with a compliant W stage
        step(0, 0, 0, 0, 0, 0, 1, 13, 32'hD0D0, 32'h500);
        for (int i = 0; i < MAX_WAIT; i++) step(1, 14, 32'h100 + i, 32'h600, 0, 0, 0, 0, 0, 0);
        chk("starve_stall", 32'(stall_req), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("starve_release", 32'(stall_req), 32'd0);

        // Starvation with a W stage that ignores the bubble request
        step(0, 0, 0, 0, 0, 0, 1, 15, 32'hE0E0, 32'h700);
        for (int i = 0; i < MAX_WAIT + 1; i++) step(1, 16, 32'h200 + i, 32'h800, 0, 0, 0, 0, 0, 0);
        chk("violate_stall", 32'(stall_req), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("violate_release", 32'(stall_req), 32'd0);

        // Same-cycle pop and issue to $9; then a discarded $0 result
        step(0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
        step(1, 17, 32'h17, 32'h900, 0, 0, 1, 9, 32'h9999, 32'h904);
        step(0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
        chk("pend9_kept", 32'(pending[9]), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD, 32'hA00);
        idle(2);

        // Reset mid-operation
        step(1, 18, 32'h18, 32'hB00, 1, 20, 1, 20, 32'h2020, 32'hB04);
        step(1, 19, 32'h19, 32'hB08, 1, 21, 1, 21, 32'h2121, 32'hB0C);
        #2 reset = 1'b0;
        model_clear();
        #1;
        chk("rstmid_pending", pending, 32'd0);
        chk("rstmid_lu_ready", 32'(lu_ready), 32'd0);
        chk("rstmid_grf_we", 32'(grf_we), 32'd0);
        chk("rstmid_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        step(1, 22, 32'h22, 32'hC00, 0, 0, 1, 22, 32'h2222, 32'hC04);
        reset = 1'b1;
        idle(3);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if (m_stall) pw = ($urandom_range(0, 7) == 0);
            else         pw = ($urandom_range(0, 99) < 60);
            step(pw, 5'($urandom), $urandom, $urandom,
                 ($urandom_range(0, 3) == 0), 5'($urandom),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                 $urandom, $urandom);
        end
        idle(8);
        chk("exp_drained", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
